// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: run-time selectable ring/Johnson shift counter with self-correction, position decode and wrap pulse
module ring_johnson_counter #(
  parameter int WIDTH = 4,
  parameter int POS_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             illegal
);
  logic [WIDTH-1:0] rv, sh;
  logic [WIDTH-2:0] t;
  int cnt, idx;
  always_comb begin
    rv = mode ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    sh = dir ? {q[WIDTH-2:0], q[WIDTH-1] ^ mode} : {q[0] ^ mode, q[WIDTH-1:1]};
    t = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    illegal = mode ? |(t & (t - (WIDTH-1)'(1))) : (q == '0 || |(q & (q - WIDTH'(1))));
    cnt = 0;
    idx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + int'(q[i]);
      if (q[i]) idx = i;
    end
    pos = illegal ? '0 : mode ? (q[0] ? POS_W'(2*WIDTH - cnt) : POS_W'(cnt)) : POS_W'(WIDTH - 1 - idx);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rv;
      wrap <= 1'b0;
    end else if (load) begin
      q <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      q <= illegal ? rv : sh;
      wrap <= !illegal && sh == rv;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb_ring_johnson_counter: directed self-checking bench for ring_johnson_counter at WIDTH=4
module tb_ring_johnson_counter;
  logic clk = 0, rst = 0, en = 0, mode = 0, dir = 0, load = 0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic [2:0] pos;
  logic wrap, illegal;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] eq[$];
  logic [2:0] ep[$];
  logic ew[$];
  ring_johnson_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .pos(pos), .wrap(wrap), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag);
    for (int i = 0; i < eq.size(); i++) begin
      tick;
      check($sformatf("%s q[%0d]", tag, i), 32'(q), 32'(eq[i]));
      check($sformatf("%s pos[%0d]", tag, i), 32'(pos), 32'(ep[i]));
      check($sformatf("%s wrap[%0d]", tag, i), 32'(wrap), 32'(ew[i]));
      check($sformatf("%s illegal[%0d]", tag, i), 32'(illegal), 32'(0));
    end
  endtask
  initial begin
    rst = 1; tick; rst = 0;
    check("ring rst q", 32'(q), 32'b1000);
    check("ring rst pos", 32'(pos), 0);
    check("ring rst wrap", 32'(wrap), 0);
    check("ring rst illegal", 32'(illegal), 0);
    en = 1;
    eq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    ep = '{1, 2, 3, 0, 1};
    ew = '{0, 0, 0, 1, 0};
    run("ring right");
    en = 0; mode = 1; rst = 1; tick; rst = 0;
    check("john rst q", 32'(q), 0);
    check("john rst wrap", 32'(wrap), 0);
    en = 1;
    eq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    ep = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    ew = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    run("john right");
    en = 0; mode = 0; dir = 1; load = 1; load_val = 4'b0001; tick; load = 0;
    check("ring load q", 32'(q), 32'b0001);
    check("ring load pos", 32'(pos), 3);
    check("ring load wrap", 32'(wrap), 0);
    en = 1;
    eq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ep = '{2, 1, 0, 3};
    ew = '{0, 0, 1, 0};
    run("ring left");
    en = 0; load = 1; load_val = 4'b0110; tick; load = 0;
    check("bad load q", 32'(q), 32'b0110);
    check("bad load illegal", 32'(illegal), 1);
    check("bad load pos", 32'(pos), 0);
    tick;
    check("bad hold q", 32'(q), 32'b0110);
    en = 1; tick; en = 0;
    check("recover q", 32'(q), 32'b1000);
    check("recover illegal", 32'(illegal), 0);
    check("recover wrap", 32'(wrap), 0);
    load = 1; load_val = 4'b1100; tick; load = 0;
    check("1100 ring illegal", 32'(illegal), 1);
    mode = 1; dir = 0; #1;
    check("1100 john illegal", 32'(illegal), 0);
    check("1100 john pos", 32'(pos), 2);
    en = 1; tick; en = 0;
    check("mode step q", 32'(q), 32'b1110);
    check("mode step pos", 32'(pos), 3);
    load = 1; load_val = 4'b0101; tick; load = 0;
    check("john bad illegal", 32'(illegal), 1);
    en = 1; tick; en = 0;
    check("john recover q", 32'(q), 0);
    check("john recover wrap", 32'(wrap), 0);
    dir = 1;
    eq = '{4'b0001, 4'b0011};
    ep = '{7, 6};
    ew = '{0, 0};
    en = 1;
    run("john left");
    en = 0; mode = 0; load = 1; load_val = 4'b0010; tick;
    check("pre rst q", 32'(q), 32'b0010);
    rst = 1; en = 1; load_val = 4'b1111; tick; rst = 0;
    check("rst prio q", 32'(q), 32'b1000);
    check("rst prio wrap", 32'(wrap), 0);
    load_val = 4'b0001; tick; load = 0; en = 0;
    check("load prio q", 32'(q), 32'b0001);
    check("load prio wrap", 32'(wrap), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
